store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
Store-side data formatter between the execute stage and the data-memory write port. It accepts one store per handshake (SB/SH/SW by funct3) and positions the data into word lanes. It generates byte strobes and issues one or two word-aligned memory write beats. A second beat is issued when a halfword or word crosses a 32-bit boundary. It is the write-direction counterpart of the load sign-extension path.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, data/word width; only 32 supported (4 byte lanes).
ALLOW_MISALIGNED, 1, 1 = split boundary-crossing stores into two beats; 0 = reject them with err.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  store request valid.
req_ready  output  1  unit can accept a request.
req_addr  input  ADDR_WIDTH  byte address.
req_data  input  DATA_WIDTH  store data, right-justified (byte in [7:0], half in [15:0]).
req_funct3  input  3  000 SB, 001 SH, 010 SW.
mem_valid  output  1  write beat valid.
mem_ready  input  1  memory accepts beat.
mem_addr  output  ADDR_WIDTH  word-aligned address, bits [1:0] always 00.
mem_wdata  output  DATA_WIDTH  lane-positioned write data; non-strobed lanes 0.
mem_wstrb  output  4  byte enables; bit i covers byte lane i.
done  output  1  one-cycle pulse: store fully written.
err  output  1  one-cycle pulse: request rejected, no memory beat issued.

Behaviour:
- Reset (async, active-high): state IDLE; mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, done=0, err=0. req_ready=1 after reset deasserts.
- req_ready = (state==IDLE). A request is accepted on a cycle with req_valid & req_ready.
- Formatting at accept, with o=req_addr[1:0]:
  - mask is 0001 for SB, 0011 for SH, 1111 for SW.
  - d = data masked to size (upper bits zeroed).
  - strb8[7:0] = mask << o.
  - data64 = d << (8*o).
- States: IDLE, BEAT0, BEAT1.
- IDLE, legal funct3, and (strb8[7:4]==0 or ALLOW_MISALIGNED=1) -> BEAT0 next cycle.
  - mem_valid=1, mem_addr={addr[31:2],00}, mem_wdata=data64[31:0], mem_wstrb=strb8[3:0].
  - Hold strb8[7:4], data64[63:32] and {addr[31:2],00}+4 (modulo 2^ADDR_WIDTH, wraps FFFFFFFC -> 00000000).
- IDLE, illegal funct3 (any of 011,1xx), or crossing with ALLOW_MISALIGNED=0: err=1 next cycle, stay IDLE, no beat.
- BEAT0 & mem_ready:
  - if high strobes != 0 -> BEAT1 with the held values, mem_valid stays 1;
  - else -> IDLE, mem_valid=0, done=1 next cycle.
- BEAT1 & mem_ready -> IDLE, mem_valid=0, done=1 next cycle.
- While mem_valid & !mem_ready, mem_addr/mem_wdata/mem_wstrb are held stable.
- Latency (accept at cycle N, mem_ready always 1):
  - single beat: mem_valid at N+1; done and req_ready at N+2.
  - two beats: done at N+3.
- A new request may be accepted in the same cycle done is high (state is IDLE). done and err are never high together.
- Reset mid-operation aborts the store: mem_valid drops immediately, no done, and no beat is replayed.

Decomposition:
- Package store_pkg:
  - funct3 constants F3_SB=000, F3_SH=001, F3_SW=010;
  - state enum store_state_t {IDLE, BEAT0, BEAT1};
  - lane-count constant NUM_LANES = DATA_WIDTH/8.
- Sub-module store_align: combinational; inputs addr[1:0], funct3, data; outputs strb8, data64, legal, crosses. The FSM and registers live in store_unit.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, mem_ready=1 -> one beat: addr 0x100, wdata 0xDEADBEEF, wstrb 1111; done at N+2.
- SB, addr 0x203, data 0x123456AB -> addr 0x200, wdata 0xAB000000, wstrb 1000, single beat.
- SH, addr 0x3, data 0xCAFE, ALLOW_MISALIGNED=1 -> beat0: addr 0x0, wdata 0xFE000000, wstrb 1000; beat1: addr 0x4, wdata 0x000000CA, wstrb 0001; done at N+3. Same stimulus with ALLOW_MISALIGNED=0 -> err pulse, no mem_valid.
- SW, addr 0xFFFFFFFE, data 0x11223344 -> beat0: addr 0xFFFFFFFC, wdata 0x33440000, wstrb 1100; beat1: addr 0x00000000, wdata 0x00001122, wstrb 0011.
- SW, mem_ready low for 3 cycles -> mem_addr/mem_wdata/mem_wstrb held stable; req_ready=0 throughout; done one cycle after the handshake.
- funct3=100 -> err=1 at N+1, req_ready stays 1. Separately, assert rst while in BEAT1 -> mem_valid=0 immediately, done never pulses.

Source files
------------

// File: rtl/store_pkg.sv
// store_pkg: shared constants and state type for the store formatter.
package store_pkg;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_LANES = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} store_state_t;
endpackage

// File: rtl/store_align.sv
// store_align: positions store data and byte strobes across two adjacent words.
module store_align
  import store_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [7:0]  strb8,
  output logic [63:0] data64,
  output logic        legal,
  output logic        crosses
);
  logic [3:0] mask;
  logic [31:0] d;
  always_comb begin
    mask = funct3 == F3_SB ? 4'b0001 : funct3 == F3_SH ? 4'b0011 : 4'b1111;
    d = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    strb8 = {4'b0000, mask} << addr;
    data64 = {32'h0, d} << {addr, 3'b000};
    legal = funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW;
    crosses = |strb8[7:4];
  end
endmodule

// File: rtl/store_unit.sv
// store_unit: turns SB/SH/SW requests into one or two word-aligned strobed write beats.
module store_unit
  import store_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [2:0]            req_funct3,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic                  done,
  output logic                  err
);
  store_state_t state;
  logic [7:0] strb8;
  logic [63:0] data64;
  logic legal, crosses, accept, reject;
  logic [ADDR_WIDTH-1:0] base, hi_addr;
  logic [DATA_WIDTH-1:0] hi_data;
  logic [3:0] hi_strb;

  store_align u_align (
    .addr(req_addr[1:0]), .funct3(req_funct3), .data(req_data),
    .strb8(strb8), .data64(data64), .legal(legal), .crosses(crosses)
  );

  assign req_ready = state == IDLE;
  assign mem_valid = state != IDLE;
  assign accept = req_valid && req_ready;
  assign reject = !legal || (crosses && ALLOW_MISALIGNED == 0);
  assign base = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      hi_addr <= '0;
      hi_data <= '0;
      hi_strb <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (accept) begin
        if (reject) err <= 1'b1;
        else begin
          state <= BEAT0;
          mem_addr <= base;
          mem_wdata <= data64[31:0];
          mem_wstrb <= strb8[3:0];
          hi_addr <= base + ADDR_WIDTH'(4);
          hi_data <= data64[63:32];
          hi_strb <= strb8[7:4];
        end
      end else if (mem_valid && mem_ready) begin
        if (state == BEAT0 && |hi_strb) begin
          state <= BEAT1;
          mem_addr <= hi_addr;
          mem_wdata <= hi_data;
          mem_wstrb <= hi_strb;
        end else begin
          state <= IDLE;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed and random stores checked against a byte-level memory-write model.
module tb_store_unit;
  logic clk = 0, rst = 1;
  logic req_valid = 0, mem_ready = 0;
  logic [31:0] req_addr = 0, req_data = 0;
  logic [2:0] req_funct3 = 0;
  logic req_ready, mem_valid, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic r0_valid = 0, m0_ready = 1;
  logic [31:0] r0_addr = 0, r0_data = 0;
  logic [2:0] r0_funct3 = 0;
  logic r0_ready, m0_valid, d0_done, d0_err;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0] m0_wstrb;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  store_unit #(.ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .done(done), .err(err)
  );

  store_unit #(.ALLOW_MISALIGNED(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(r0_valid), .req_ready(r0_ready),
    .req_addr(r0_addr), .req_data(r0_data), .req_funct3(r0_funct3),
    .mem_valid(m0_valid), .mem_ready(m0_ready), .mem_addr(m0_addr),
    .mem_wdata(m0_wdata), .mem_wstrb(m0_wstrb), .done(d0_done), .err(d0_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: each store byte i lands at byte address addr+i; group those bytes by word.
  task automatic do_store(input logic [31:0] a, input logic [31:0] dat, input logic [2:0] f3, input int max_stall);
    logic [31:0] ea[2], ed[2];
    logic [3:0] es[2];
    int size, nb, idx, lane;
    bit legal;
    legal = f3 <= 3'd2;
    size = f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4;
    es[0] = 0; es[1] = 0; ed[0] = 0; ed[1] = 0;
    ea[0] = a & 32'hFFFF_FFFC;
    ea[1] = ea[0] + 32'd4;
    for (int i = 0; i < size; i++) begin
      idx = (int'(a[1:0]) + i) / 4;
      lane = (int'(a[1:0]) + i) % 4;
      es[idx][lane] = 1'b1;
      ed[idx][8*lane +: 8] = dat[8*i +: 8];
    end
    nb = es[1] != 0 ? 2 : 1;
    chk("ready_before_req", req_ready, 1);
    req_valid = 1; req_addr = a; req_data = dat; req_funct3 = f3;
    step();
    req_valid = 0;
    if (!legal) begin
      chk("illegal_err", err, 1);
      chk("illegal_no_beat", mem_valid, 0);
      chk("illegal_ready", req_ready, 1);
      chk("illegal_no_done", done, 0);
      step();
      chk("illegal_err_pulse", err, 0);
      return;
    end
    chk("accept_no_err", err, 0);
    for (int b = 0; b < nb; b++) begin
      int stall = $urandom_range(0, max_stall);
      for (int s = 0; s <= stall; s++) begin
        chk("beat_valid", mem_valid, 1);
        chk("beat_addr", mem_addr, ea[b]);
        chk("beat_wdata", mem_wdata, ed[b]);
        chk("beat_wstrb", mem_wstrb, es[b]);
        chk("busy_not_ready", req_ready, 0);
        chk("busy_no_done", done, 0);
        mem_ready = s == stall;
        step();
      end
      mem_ready = 0;
    end
    chk("done_pulse", done, 1);
    chk("done_no_err", err, 0);
    chk("done_idle", mem_valid, 0);
    chk("done_ready", req_ready, 1);
  endtask

  initial begin
    #1;
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    step();
    rst = 0;
    step();
    chk("rst_ready", req_ready, 1);
    do_store(32'h100, 32'hDEADBEEF, 3'b010, 0);
    do_store(32'h203, 32'h123456AB, 3'b000, 0);
    do_store(32'h3, 32'h0000CAFE, 3'b001, 0);
    do_store(32'hFFFFFFFE, 32'h11223344, 3'b010, 0);
    do_store(32'h40, 32'h55667788, 3'b010, 3);
    do_store(32'h41, 32'h99AABBCC, 3'b001, 2);
    do_store(32'h80, 32'h0, 3'b100, 0);
    do_store(32'h84, 32'h1, 3'b011, 0);
    for (int k = 0; k < 60; k++) begin
      logic [2:0] f3;
      f3 = $urandom_range(0, 9) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      do_store($urandom, $urandom, f3, 3);
    end
    // Rejection of a boundary-crossing halfword on the strict instance.
    r0_valid = 1; r0_addr = 32'h3; r0_data = 32'hCAFE; r0_funct3 = 3'b001;
    step();
    r0_valid = 0;
    chk("strict_err", d0_err, 1);
    chk("strict_no_beat", m0_valid, 0);
    chk("strict_ready", r0_ready, 1);
    step();
    chk("strict_err_pulse", d0_err, 0);
    chk("strict_still_idle", m0_valid, 0);
    // Reset while the second beat is outstanding.
    req_valid = 1; req_addr = 32'hFFFFFFFE; req_data = 32'h11223344; req_funct3 = 3'b010;
    step();
    req_valid = 0;
    mem_ready = 1;
    step();
    mem_ready = 0;
    chk("pre_rst_beat1", mem_wstrb, 4'b0011);
    chk("pre_rst_valid", mem_valid, 1);
    rst = 1;
    #1;
    chk("async_rst_valid", mem_valid, 0);
    chk("async_rst_done", done, 0);
    mem_ready = 1;
    step();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_no_done", done, 0);
      chk("post_rst_no_valid", mem_valid, 0);
      chk("post_rst_ready", req_ready, 1);
    end
    mem_ready = 0;
    do_store(32'h10, 32'hA5A5A5A5, 3'b010, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
